silife_grid: RTL
================

Name: silife_grid

Overview:
- Parametrised successor to the fixed 8x8 Game-of-Life grid: WIDTH x HEIGHT cell array evolving under B3/S23 rules.
- Adds toroidal wrap mode, single-step control, a generation counter, a registered population count and stable/extinct status flags.
- Edge neighbour ports remain, so instances can still be tiled into larger fabrics when wrap is off.
- Sits directly under the Tiny Tapeout top wrapper, replacing the 8x8 grid.

Parameters:
- WIDTH, 8, columns per row; bit 0 = west edge, 2..32.
- HEIGHT, 8, number of rows; row 0 = north edge, 2..32.
- ROW_W, $clog2(HEIGHT), width of row_select.
- GEN_W, 16, generation counter width.
- POP_W, $clog2(WIDTH*HEIGHT+1), population count width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous reset, active-high.
- enable  in  1  run: evolve one generation on every clock edge.
- step  in  1  single-step: evolve one generation this cycle, even when enable=0.
- wrap  in  1  1 = toroidal edges (i_* ignored); 0 = neighbours come from i_* ports.
- row_select  in  ROW_W  row address for both write and read.
- set_cells  in  WIDTH  bits to set in the selected row.
- clear_cells  in  WIDTH  bits to clear in the selected row.
- cells  out  WIDTH  combinational readout of the selected row (current state).
- i_n, i_s  in  WIDTH  neighbour rows outside the north and south edges.
- i_w, i_e  in  HEIGHT  neighbour columns outside the west and east edges.
- i_nw, i_ne, i_sw, i_se  in  1  corner neighbours.
- o_n, o_s  out  WIDTH  row 0 and row HEIGHT-1 state.
- o_w, o_e  out  HEIGHT  column 0 and column WIDTH-1 state.
- generation  out  GEN_W  count of evolutions since reset.
- population  out  POP_W  registered count of live cells.
- stable  out  1  last evolution produced no change.
- extinct  out  1  population == 0 (registered).

Behaviour:
- Reset (reset=1 at an edge): all cells=0, generation=0, population=0, stable=0, extinct=1. Reset overrides evolve and write in the same cycle, so a reset mid-run loses the grid.
- Evolve condition: evo = enable | step. When enable=1, step is redundant and no double-advance occurs.
- Next state per cell: n = live count of 8 neighbours. next = (n==3) | (cur & n==2).
- Neighbour sourcing:
  - wrap=1: indices taken modulo WIDTH and HEIGHT.
  - wrap=0: off-grid neighbours come from i_n/i_s/i_w/i_e and the corner ports. i_n[x] is the cell north of (0,x). i_w[y] is the cell west of (y,0).
- All cells update simultaneously from the pre-edge state.
- Write: each cycle the selected row gets row' = (base & ~clear_cells) | set_cells.
  - base is the evolved row if evo=1, otherwise the current row.
  - Set wins over clear on the same bit.
  - Writes always apply and are independent of evo.
- row_select >= HEIGHT (non-power-of-two HEIGHT): write ignored, cells reads 0.
- cells and o_* are combinational from state registers. Zero latency; they show the new state the cycle after an edge.
- generation increments by 1 on each evo cycle and wraps from 2^GEN_W-1 to 0.
- population and extinct reflect the state registered one cycle earlier (latency 1 after the state changes).
- stable is updated only on evo cycles: 1 iff the evolved grid equals the pre-evolve grid, ignoring writes. It holds its value otherwise.

Decomposition:
- Package silife_pkg holds:
  - BIRTH_N=3, SURVIVE_LO=2, SURVIVE_HI=3;
  - function life_next(cur, n[3:0]);
  - function popcount helper.
- Sub-module silife_cell: 1-bit state register plus neighbour counter, inputs clk/reset/evo/8 neighbours/set/clear, output state. Instantiated via generate over the HEIGHT x WIDTH array.
- Top level handles neighbour muxing, readout, counters and flags.

Test Plan:
- Blinker: write row 3 = 8'b00011100, enable=0, one step pulse. Expect rows 2, 3, 4 = 8'b00001000, generation=1, stable=0. A second step restores the row-3 pattern.
- Glider, wrap=1, 8x8: run 32 generations. Expect the original pattern, translated back to its start, generation=32, population=5 throughout.
- Glider, wrap=0, i_*=0: the glider exits the south-east corner. Expect it to decay to a 2x2 block or to extinct=1 (compare against golden model); o_s/o_e show the edge rows/columns each cycle.
- Write priority: step=1 with set_cells=clear_cells=8'hFF on row 0. Expect row 0 = 8'hFF after the edge. With set=0, clear=8'h0F, expect row 0 lower nibble 0 and upper nibble = evolved value.
- Still life: a 2x2 block, enable=1 for 3 cycles. Expect stable=1 and population=4 (one cycle late); generation counts 1, 2, 3.
- Reset mid-run during enable=1: next cycle shows cells=0, generation=0, extinct=1. With GEN_W=3, 9 steps give generation=1 (wrap).

Source files
------------

// File: rtl/silife_pkg.sv
// Shared Game-of-Life rule constants and helpers for the silife grid.
// B3/S23: birth on exactly three neighbours, survival on two or three.
package silife_pkg;

    localparam int BIRTH_N    = 3;
    localparam int SURVIVE_LO = 2;
    localparam int SURVIVE_HI = 3;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] acc;
        acc = '0;
        for (int i = 0; i < 8; i++) begin
            acc = acc + {3'b000, v[i]};
        end
        return acc;
    endfunction

    function automatic logic life_next(input logic cur, input logic [3:0] n);
        return (n == 4'(BIRTH_N)) ||
               (cur && (n >= 4'(SURVIVE_LO)) && (n <= 4'(SURVIVE_HI)));
    endfunction

endpackage

// File: rtl/silife_cell.sv
// One grid cell: state flop, neighbour count and row-write overlay.
// The write (set beats clear) is applied on top of the evolved or held value.
module silife_cell
    import silife_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       evo,
    input  logic [7:0] nbr,
    input  logic       set,
    input  logic       clear,
    output logic       evolved,
    output logic       state
);

    logic state_q;
    logic state_d;

    assign evolved = life_next(state_q, popcount8(nbr));

    always_comb begin
        state_d = ((evo ? evolved : state_q) & ~clear) | set;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= 1'b0;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/silife_grid.sv
// WIDTH x HEIGHT Game-of-Life array with wrap/edge-port neighbour sourcing,
// row write/readout, generation counter, registered population and status flags.
module silife_grid
    import silife_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int HEIGHT = 8,
    parameter int ROW_W  = $clog2(HEIGHT),
    parameter int GEN_W  = 16,
    parameter int POP_W  = $clog2(WIDTH*HEIGHT+1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              step,
    input  logic              wrap,
    input  logic [ROW_W-1:0]  row_select,
    input  logic [WIDTH-1:0]  set_cells,
    input  logic [WIDTH-1:0]  clear_cells,
    output logic [WIDTH-1:0]  cells,
    input  logic [WIDTH-1:0]  i_n,
    input  logic [WIDTH-1:0]  i_s,
    input  logic [HEIGHT-1:0] i_w,
    input  logic [HEIGHT-1:0] i_e,
    input  logic              i_nw,
    input  logic              i_ne,
    input  logic              i_sw,
    input  logic              i_se,
    output logic [WIDTH-1:0]  o_n,
    output logic [WIDTH-1:0]  o_s,
    output logic [HEIGHT-1:0] o_w,
    output logic [HEIGHT-1:0] o_e,
    output logic [GEN_W-1:0]  generation,
    output logic [POP_W-1:0]  population,
    output logic              stable,
    output logic              extinct
);

    localparam int CELLS = WIDTH * HEIGHT;

    logic                  evo;
    logic [CELLS-1:0]      state_flat;
    logic [CELLS-1:0]      evolved_flat;
    logic [WIDTH-1:0]      grid [HEIGHT];
    // Grid surrounded by a one-cell halo; halo bit 0 is the west side.
    logic [WIDTH+1:0]      pad [HEIGHT+2];
    logic [HEIGHT-1:0]     row_hit;

    logic [GEN_W-1:0]      gen_q, gen_d;
    logic [POP_W-1:0]      pop_q, pop_d;
    logic                  stable_q, stable_d;
    logic                  extinct_q, extinct_d;

    assign evo = enable | step;

    assign pad[0] = wrap ? {grid[HEIGHT-1][0], grid[HEIGHT-1], grid[HEIGHT-1][WIDTH-1]}
                         : {i_ne, i_n, i_nw};
    assign pad[HEIGHT+1] = wrap ? {grid[0][0], grid[0], grid[0][WIDTH-1]}
                                : {i_se, i_s, i_sw};

    for (genvar gi = 0; gi < HEIGHT; gi++) begin : g_row
        assign grid[gi]    = state_flat[gi*WIDTH +: WIDTH];
        assign pad[gi+1]   = wrap ? {grid[gi][0], grid[gi], grid[gi][WIDTH-1]}
                                  : {i_e[gi], grid[gi], i_w[gi]};
        assign row_hit[gi] = (row_select == ROW_W'(gi));
        assign o_w[gi]     = grid[gi][0];
        assign o_e[gi]     = grid[gi][WIDTH-1];

        for (genvar gj = 0; gj < WIDTH; gj++) begin : g_col
            logic [7:0] nbr;

            assign nbr = {pad[gi][gj],   pad[gi][gj+1],   pad[gi][gj+2],
                          pad[gi+1][gj],                  pad[gi+1][gj+2],
                          pad[gi+2][gj], pad[gi+2][gj+1], pad[gi+2][gj+2]};

            silife_cell u_cell (
                .clk     (clk),
                .reset   (reset),
                .evo     (evo),
                .nbr     (nbr),
                .set     (row_hit[gi] & set_cells[gj]),
                .clear   (row_hit[gi] & clear_cells[gj]),
                .evolved (evolved_flat[gi*WIDTH + gj]),
                .state   (state_flat[gi*WIDTH + gj])
            );
        end
    end

    // Out-of-range row addresses match no row and therefore read as zero.
    always_comb begin
        cells = '0;
        for (int r = 0; r < HEIGHT; r++) begin
            if (row_select == ROW_W'(r)) begin
                cells = grid[r];
            end
        end
    end

    assign o_n = grid[0];
    assign o_s = grid[HEIGHT-1];

    always_comb begin
        gen_d = evo ? gen_q + GEN_W'(1) : gen_q;
        pop_d = '0;
        for (int k = 0; k < CELLS; k++) begin
            pop_d = pop_d + POP_W'(state_flat[k]);
        end
        extinct_d = (pop_d == '0);
        // Compares the pure evolution against the pre-edge grid; row writes are ignored.
        stable_d  = evo ? (evolved_flat == state_flat) : stable_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gen_q     <= '0;
            pop_q     <= '0;
            stable_q  <= 1'b0;
            extinct_q <= 1'b1;
        end else begin
            gen_q     <= gen_d;
            pop_q     <= pop_d;
            stable_q  <= stable_d;
            extinct_q <= extinct_d;
        end
    end

    assign generation = gen_q;
    assign population = pop_q;
    assign stable     = stable_q;
    assign extinct    = extinct_q;

endmodule
